// File: rtl/uart_telemetry_tx.sv
// uart_telemetry_tx: snapshots NUM_CHN rpm values and sends one 8N1 frame, LSB first:
//   0x91, then per channel {chn[2:0], sat[12:8]} and sat[7:0], then 0xFF.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high; a 0xFF resync byte follows release
//   tx_start_i request one frame; only honoured in IDLE
//   rpm_bus_i  NUM_CHN signed DATA_WIDTH rpm values, ch0 in the lowest field
//   busy_o     frame or resync byte in progress
//   done_o     one-cycle pulse when a frame completes
//   uart_tx    serial line, idle high
// Optional feature: define TELEM_AUTO_EN to add a periodic trigger every PERIOD_CYCLES cycles.
module uart_telemetry_tx #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHN       = 4,
    parameter int PERIOD_CYCLES = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_start_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_bus_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          uart_tx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BAUD_DIV - 1);
    localparam logic [1:0] LAST = 2'(NUM_CHN - 1);
    localparam logic signed [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(4095);
    localparam logic signed [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(-4096);

    typedef enum logic [2:0] {RESYNC, IDLE, CMD, HI, LO, ENDB} state_t;
    state_t state, state_n;
    logic [1:0] chn, chn_n;
    logic [NUM_CHN*DATA_WIDTH-1:0] snap;
    logic [8:0] sh;
    logic [3:0] bit_cnt;
    logic [BW-1:0] baud;
    logic arm, tx, done, done_n, go, accept, byte_done;
    logic [7:0] nb;
    logic [12:0] sat [NUM_CHN];

    for (genvar i = 0; i < NUM_CHN; i++) begin : g_sat
        assign sat[i] = $signed(snap[i*DATA_WIDTH +: DATA_WIDTH]) > SMAX ? 13'h0FFF :
                        $signed(snap[i*DATA_WIDTH +: DATA_WIDTH]) < SMIN ? 13'h1000 :
                        snap[i*DATA_WIDTH +: 13];
    end

`ifdef TELEM_AUTO_EN
    localparam int PW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
    logic [PW-1:0] pcnt;
    logic trig;
    assign trig = pcnt == PW'(PERIOD_CYCLES - 1);
    always_ff @(posedge clk) pcnt <= (rst || trig) ? '0 : pcnt + 1'b1;
    assign go = tx_start_i | trig;
`else
    logic unused_period;
    assign unused_period = |PERIOD_CYCLES;
    assign go = tx_start_i;
`endif

    assign accept    = state == IDLE && go;
    assign byte_done = state != IDLE && !arm && baud == BLAST && bit_cnt == 4'd9;

    always_comb begin
        state_n = state;
        chn_n   = chn;
        done_n  = 1'b0;
        case (state)
            IDLE:   if (go) begin state_n = CMD; chn_n = '0; end
            RESYNC: if (byte_done) state_n = IDLE;
            CMD:    if (byte_done) state_n = HI;
            HI:     if (byte_done) state_n = LO;
            LO:     if (byte_done) begin
                        state_n = chn == LAST ? ENDB : HI;
                        chn_n   = chn == LAST ? chn : chn + 1'b1;
                    end
            ENDB:   if (byte_done) begin state_n = IDLE; done_n = 1'b1; end
            default: state_n = IDLE;
        endcase
        // byte for the state being entered, so the next byte follows with no gap
        nb = state_n == CMD ? 8'h91 :
             state_n == HI  ? {1'b0, chn_n, sat[chn_n][12:8]} :
             state_n == LO  ? sat[chn_n][7:0] : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESYNC;
            chn     <= '0;
            snap    <= '0;
            sh      <= 9'h1FF;
            bit_cnt <= '0;
            baud    <= '0;
            arm     <= 1'b1;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            chn   <= chn_n;
            done  <= done_n;
            // arm holds the line high for one cycle before the first start bit
            if (accept) begin
                snap <= rpm_bus_i;
                sh   <= {1'b1, nb};
                arm  <= 1'b1;
            end else if (arm) begin
                arm     <= 1'b0;
                tx      <= 1'b0;
                bit_cnt <= '0;
                baud    <= '0;
            end else if (state != IDLE) begin
                if (baud != BLAST) begin
                    baud <= baud + 1'b1;
                end else if (byte_done) begin
                    baud    <= '0;
                    bit_cnt <= '0;
                    tx      <= state_n == IDLE;
                    sh      <= {1'b1, nb};
                end else begin
                    baud    <= '0;
                    tx      <= sh[0];
                    sh      <= {1'b0, sh[8:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o  = state != IDLE && !rst;
    assign done_o  = done;
    assign uart_tx = tx;
endmodule
